// File: rtl/cpu8_pkg.sv
// Shared types for the CPU8 boot loader: loader FSM states and the default frame header.
package cpu8_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } ldr_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // States in which the loader offers rx_ready.
  function automatic logic rx_state(input ldr_state_t st);
    return (st == ST_SYNC) || (st == ST_LEN) || (st == ST_DATA) || (st == ST_CHK);
  endfunction

  // States in which the inter-byte timeout is armed.
  function automatic logic timed_state(input ldr_state_t st);
    return (st == ST_LEN) || (st == ST_DATA) || (st == ST_CHK);
  endfunction

endpackage

// File: rtl/ldr_timer.sv
// Clearable inter-byte timeout counter; expired stays high once TIMEOUT cycles have been counted.
module ldr_timer #(
  parameter int TIMEOUT = 1000000
) (
  input  logic CLK,
  input  logic CLRn,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = (cnt_q >= CW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLRn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a SYNC/LEN/DATA/CHK frame, writes the data bytes into
// program RAM and holds the CPU in reset until a frame verifies.
module prog_loader
  import cpu8_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(SYNC_BYTE_DEF),
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                TIMEOUT   = 1000000
) (
  input  logic              CLK,
  input  logic              CLRn,
  input  logic              start,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              ram_we_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              cpu_clrn,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] byte_cnt
);

  ldr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              cpu_clrn_q, cpu_clrn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic              timer_clr;
  logic              timer_run;
  logic              timer_exp;
  logic [DATA_W-1:0] chk_total;
  logic [ADDR_W-1:0] cnt_inc;

  ldr_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .CLK    (CLK),
    .CLRn   (CLRn),
    .clr    (timer_clr),
    .run    (timer_run),
    .expired(timer_exp)
  );

  assign rx_ready  = rx_state(state_q);
  assign accept    = rx_valid && rx_ready;
  assign timer_run = timed_state(state_q);
  // Held clear while hunting for SYNC so a stale count never leaks into the next frame.
  assign timer_clr = accept || (state_q == ST_SYNC);
  assign chk_total = sum_q + rx_data;
  assign cnt_inc   = byte_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    sum_d      = sum_q;
    len_d      = len_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    cpu_clrn_d = cpu_clrn_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_SYNC;
          cpu_clrn_d = 1'b0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          byte_cnt_d = '0;
          sum_d      = '0;
        end
      end
      ST_SYNC: begin
        if (accept && (rx_data == SYNC_BYTE)) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (accept) begin
          if (rx_data == '0) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            len_d   = rx_data;
            state_d = ST_DATA;
          end
        end else if (timer_exp) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_DATA: begin
        // Address and data are registered here so they are stable for the whole WRITE cycle.
        if (accept) begin
          sum_d      = sum_q + rx_data;
          ram_addr_d = BASE_ADDR + byte_cnt_q;
          ram_din_d  = rx_data;
          state_d    = ST_WRITE;
        end else if (timer_exp) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_WRITE: begin
        byte_cnt_d = cnt_inc;
        state_d    = (cnt_inc == ADDR_W'(len_q)) ? ST_CHK : ST_DATA;
      end
      ST_CHK: begin
        if (accept) begin
          busy_d = 1'b0;
          if (chk_total == '0) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            cpu_clrn_d = 1'b1;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end else if (timer_exp) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CLRn) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      sum_q      <= '0;
      len_q      <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      cpu_clrn_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      sum_q      <= sum_d;
      len_q      <= len_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      cpu_clrn_q <= cpu_clrn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ram_we_n = (state_q != ST_WRITE);
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign cpu_clrn = cpu_clrn_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of frames plus hand sequences for busy-start, timeout and reset.
module tb_prog_loader;

  localparam int TMO = 40;

  logic       CLK = 1'b0;
  logic       CLRn;
  logic       start;
  logic [7:0] rx_data;
  logic       rx_valid;

  logic       rx_ready, ram_we_n, cpu_clrn, busy, done, err;
  logic [7:0] ram_addr, ram_din, byte_cnt;
  logic       rx_ready2, ram_we_n2, cpu_clrn2, busy2, done2, err2;
  logic [7:0] ram_addr2, ram_din2, byte_cnt2;

  int checks = 0;
  int errors = 0;

  logic [15:0] wq1[$];
  logic [15:0] wq2[$];

  always #10 CLK = ~CLK;

  prog_loader #(.ADDR_W(8), .DATA_W(8), .SYNC_BYTE(8'hA5), .BASE_ADDR(8'h00), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .CLRn(CLRn), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .ram_we_n(ram_we_n), .ram_addr(ram_addr), .ram_din(ram_din),
    .cpu_clrn(cpu_clrn), .busy(busy), .done(done), .err(err), .byte_cnt(byte_cnt)
  );

  prog_loader #(.ADDR_W(8), .DATA_W(8), .SYNC_BYTE(8'hA5), .BASE_ADDR(8'hFE), .TIMEOUT(TMO)) dut2 (
    .CLK(CLK), .CLRn(CLRn), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready2), .ram_we_n(ram_we_n2), .ram_addr(ram_addr2), .ram_din(ram_din2),
    .cpu_clrn(cpu_clrn2), .busy(busy2), .done(done2), .err(err2), .byte_cnt(byte_cnt2)
  );

  always @(negedge CLK) begin
    if (!ram_we_n)  wq1.push_back({ram_addr, ram_din});
    if (!ram_we_n2) wq2.push_back({ram_addr2, ram_din2});
  end

  typedef struct {
    int             n;
    logic [0:7][7:0] b;
    logic           done;
    logic           err;
    logic           clrn;
    int             nwr;
    logic [7:0]     cnt;
    int             fd;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(int n, logic [63:0] bytes, logic d, logic e, logic c,
                              int nwr, logic [7:0] cnt, int fd);
    vec_t v;
    v.n = n; v.b = bytes; v.done = d; v.err = e; v.clrn = c;
    v.nwr = nwr; v.cnt = cnt; v.fd = fd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      tick(1);
      n++;
    end
    if (n >= 20) begin
      chk("rx_ready_wait", 32'(rx_ready), 32'd1);
    end else begin
      tick(1);
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = mk(6, {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A, 16'h0}, 1, 0, 1, 3, 8'd3, 2);
    vecs[1] = mk(6, {8'h00, 8'h7F, 8'hA5, 8'h01, 8'h05, 8'hFB, 16'h0}, 1, 0, 1, 1, 8'd1, 4);
    vecs[2] = mk(5, {8'hA5, 8'h02, 8'h01, 8'h02, 8'h00, 24'h0},        0, 1, 0, 2, 8'd2, 2);
    vecs[3] = mk(2, {8'hA5, 8'h00, 48'h0},                              0, 1, 0, 0, 8'd0, 2);
    vecs[4] = mk(4, {8'hA5, 8'h01, 8'hFF, 8'h01, 32'h0},               1, 0, 1, 1, 8'd1, 2);
    vecs[5] = mk(6, {8'hA5, 8'h03, 8'h01, 8'h01, 8'h01, 8'hFD, 16'h0}, 1, 0, 1, 3, 8'd3, 2);

    CLRn = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick(3);
    chk("rst_rx_ready", 32'(rx_ready), 0);
    chk("rst_we_n", 32'(ram_we_n), 1);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_din", 32'(ram_din), 0);
    chk("rst_cpu_clrn", 32'(cpu_clrn), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_byte_cnt", 32'(byte_cnt), 0);
    CLRn = 1'b1;
    tick(1);
    chk("idle_no_ready", 32'(rx_ready), 0);

    for (int i = 0; i < 6; i++) begin
      wq1.delete();
      wq2.delete();
      pulse_start();
      chk($sformatf("v%0d_busy_start", i), 32'(busy), 1);
      chk($sformatf("v%0d_clrn_held", i), 32'(cpu_clrn), 0);
      for (int j = 0; j < vecs[i].n; j++) send(vecs[i].b[j]);
      tick(2);
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].done));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
      chk($sformatf("v%0d_cpu_clrn", i), 32'(cpu_clrn), 32'(vecs[i].clrn));
      chk($sformatf("v%0d_busy_end", i), 32'(busy), 0);
      chk($sformatf("v%0d_byte_cnt", i), 32'(byte_cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_nwrites", i), 32'(wq1.size()), 32'(vecs[i].nwr));
      chk($sformatf("v%0d_nwrites_fe", i), 32'(wq2.size()), 32'(vecs[i].nwr));
      for (int k = 0; k < vecs[i].nwr; k++) begin
        logic [7:0] a2;
        a2 = 8'hFE + 8'(k);
        if (k < wq1.size())
          chk($sformatf("v%0d_wr%0d", i, k), 32'(wq1[k]), 32'({8'(k), vecs[i].b[vecs[i].fd + k]}));
        if (k < wq2.size())
          chk($sformatf("v%0d_wr%0d_fe", i, k), 32'(wq2[k]), 32'({a2, vecs[i].b[vecs[i].fd + k]}));
      end
    end

    // start while busy is ignored; write latency blocks the next byte for one cycle
    wq1.delete();
    pulse_start();
    send(8'hA5);
    send(8'h02);
    send(8'h10);
    chk("lat_write_cycle_we", 32'(ram_we_n), 0);
    chk("lat_write_cycle_ready", 32'(rx_ready), 0);
    chk("lat_write_addr", 32'({ram_addr, ram_din}), 32'h0010);
    tick(1);
    chk("lat_ready_again", 32'(rx_ready), 1);
    chk("lat_addr_hold", 32'({ram_addr, ram_din}), 32'h0010);
    pulse_start();
    chk("busy_start_ignored", 32'(busy), 1);
    send(8'h20);
    send(8'hD0);
    tick(2);
    chk("busy_start_done", 32'(done), 1);
    chk("busy_start_cnt", 32'(byte_cnt), 2);
    chk("busy_start_wrs", 32'(wq1.size()), 2);

    // inter-byte timeout inside DATA
    pulse_start();
    send(8'hA5);
    send(8'h04);
    send(8'hAA);
    tick(TMO - 10);
    chk("tmo_not_yet", 32'(err), 0);
    chk("tmo_busy_yet", 32'(busy), 1);
    tick(20);
    chk("tmo_err", 32'(err), 1);
    chk("tmo_cpu_held", 32'(cpu_clrn), 0);
    chk("tmo_busy", 32'(busy), 0);
    chk("tmo_cnt", 32'(byte_cnt), 1);

    // reset in the middle of DATA
    wq1.delete();
    pulse_start();
    send(8'hA5);
    send(8'h03);
    send(8'h11);
    tick(1);
    CLRn = 1'b0;
    tick(1);
    CLRn = 1'b1;
    chk("mid_rst_ready", 32'(rx_ready), 0);
    chk("mid_rst_we_n", 32'(ram_we_n), 1);
    chk("mid_rst_addr", 32'(ram_addr), 0);
    chk("mid_rst_din", 32'(ram_din), 0);
    chk("mid_rst_clrn", 32'(cpu_clrn), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_flags", 32'({done, err}), 0);
    chk("mid_rst_cnt", 32'(byte_cnt), 0);
    chk("mid_rst_partial_wr", 32'(wq1.size()), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
